// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state, digit and strobe definitions for the stopwatch front panel
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_PAUSE  = 2'd0,
    ST_RUN    = 2'd1,
    ST_ADJUST = 2'd2
  } sw_state_e;

  localparam logic [1:0] DIG_MIN_L = 2'd0;
  localparam logic [1:0] DIG_MIN_R = 2'd1;
  localparam logic [1:0] DIG_SEC_L = 2'd2;
  localparam logic [1:0] DIG_SEC_R = 2'd3;

  // Wrap limits packed in display order {min_l, min_r, sec_l, sec_r}.
  localparam logic [15:0] DIG_LIMITS = {4'd9, 4'd9, 4'd5, 4'd9};

  localparam logic [2:0] ADJ_IDLE   = 3'b000;
  localparam logic       ADJ_STROBE = 1'b1;

  function automatic logic [3:0] digit_limit(input logic [1:0] dig);
    logic [3:0] lim;
    case (dig)
      DIG_MIN_L: lim = DIG_LIMITS[15:12];
      DIG_MIN_R: lim = DIG_LIMITS[11:8];
      DIG_SEC_L: lim = DIG_LIMITS[7:4];
      DIG_SEC_R: lim = DIG_LIMITS[3:0];
      default:   lim = DIG_LIMITS[3:0];
    endcase
    return lim;
  endfunction

  // Anything at or above the limit (including out-of-range loads) wraps to zero.
  function automatic logic [3:0] digit_inc(input logic [3:0] val, input logic [1:0] dig);
    return (val >= digit_limit(dig)) ? 4'd0 : val + 4'd1;
  endfunction

endpackage

// File: rtl/debounce.sv
// rtl/debounce.sv - 2-flop synchronizer, hold-time debouncer and registered rising-edge pulse
module debounce #(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int DB_W            = 20,
  parameter int W               = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] stable,
  output logic [W-1:0] rise
);

  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [W-1:0]    sync1_q, sync1_d;
  logic [W-1:0]    sync2_q, sync2_d;
  logic [W-1:0]    stable_q, stable_d;
  logic [W-1:0]    prev_q, prev_d;
  logic [W-1:0]    rise_q, rise_d;
  logic [DB_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = din;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    // The hold timer only runs while the synchronised level disagrees with the accepted one.
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    prev_d = stable_q;
    rise_d = stable_q & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      prev_q   <= '0;
      rise_q   <= '0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      prev_q   <= prev_d;
      rise_q   <= rise_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;
  assign rise   = rise_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - front-panel input conditioning and RUN/PAUSE/ADJUST control for the digit counter
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int DB_W            = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_pause,
  input  logic        btn_reset,
  input  logic        btn_inc,
  input  logic        sw_adj,
  input  logic [1:0]  sw_sel,
  input  logic [15:0] cnt_digits,
  output logic        clr,
  output logic        paused,
  output logic        adj,
  output logic [2:0]  adj_sel,
  output logic [3:0]  adj_val
);

  logic       pause_press, reset_press, inc_press, adj_level;
  logic [1:0] sel_level;
  logic       pause_level_unused, reset_level_unused, inc_level_unused, adj_rise_unused;
  logic [1:0] sel_rise_unused;

  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W), .W(1)) u_db_pause (
    .clk(clk), .rst(rst), .din(btn_pause), .stable(pause_level_unused), .rise(pause_press)
  );
  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W), .W(1)) u_db_reset (
    .clk(clk), .rst(rst), .din(btn_reset), .stable(reset_level_unused), .rise(reset_press)
  );
  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W), .W(1)) u_db_inc (
    .clk(clk), .rst(rst), .din(btn_inc), .stable(inc_level_unused), .rise(inc_press)
  );
  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W), .W(1)) u_db_adj (
    .clk(clk), .rst(rst), .din(sw_adj), .stable(adj_level), .rise(adj_rise_unused)
  );
  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W), .W(2)) u_db_sel (
    .clk(clk), .rst(rst), .din(sw_sel), .stable(sel_level), .rise(sel_rise_unused)
  );

  sw_state_e  state_q, state_d;
  logic [3:0] shadow_q [4];
  logic [3:0] shadow_d [4];
  logic       clr_q, clr_d;
  logic       paused_q, paused_d;
  logic       adj_q, adj_d;
  logic [2:0] adj_sel_q, adj_sel_d;
  logic [3:0] adj_val_q, adj_val_d;
  logic [3:0] inc_val;

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    clr_d     = 1'b0;
    adj_sel_d = ADJ_IDLE;
    adj_val_d = 4'd0;
    inc_val   = digit_inc(shadow_q[sel_level], sel_level);
    if (reset_press) begin
      clr_d = 1'b1;
      if (state_q == ST_ADJUST) begin
        shadow_d = '{default: 4'd0};
      end else begin
        state_d = ST_PAUSE;
      end
    end else begin
      case (state_q)
        ST_PAUSE, ST_RUN: begin
          if (adj_level) begin
            state_d             = ST_ADJUST;
            shadow_d[DIG_MIN_L] = cnt_digits[15:12];
            shadow_d[DIG_MIN_R] = cnt_digits[11:8];
            shadow_d[DIG_SEC_L] = cnt_digits[7:4];
            shadow_d[DIG_SEC_R] = cnt_digits[3:0];
          end else if (pause_press) begin
            state_d = (state_q == ST_PAUSE) ? ST_RUN : ST_PAUSE;
          end
        end
        ST_ADJUST: begin
          // Leaving ADJUST takes precedence over a coincident increment.
          if (!adj_level) begin
            state_d = ST_PAUSE;
          end else if (inc_press) begin
            shadow_d[sel_level] = inc_val;
            adj_sel_d           = {ADJ_STROBE, sel_level};
            adj_val_d           = inc_val;
          end
        end
        default: state_d = ST_PAUSE;
      endcase
    end
    paused_d = (state_d != ST_RUN);
    adj_d    = (state_d == ST_ADJUST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_PAUSE;
      shadow_q  <= '{default: 4'd0};
      clr_q     <= 1'b0;
      paused_q  <= 1'b1;
      adj_q     <= 1'b0;
      adj_sel_q <= ADJ_IDLE;
      adj_val_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      clr_q     <= clr_d;
      paused_q  <= paused_d;
      adj_q     <= adj_d;
      adj_sel_q <= adj_sel_d;
      adj_val_q <= adj_val_d;
    end
  end

  assign clr     = clr_q;
  assign paused  = paused_q;
  assign adj     = adj_q;
  assign adj_sel = adj_sel_q;
  assign adj_val = adj_val_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - scoreboard bench for stopwatch_ctrl with a four-clock debounce window
module tb_stopwatch_ctrl;

  localparam int DB  = 4;
  localparam int LAT = DB + 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_pause, btn_reset, btn_inc, sw_adj;
  logic [1:0]  sw_sel;
  logic [15:0] cnt_digits;
  logic        clr, paused, adj;
  logic [2:0]  adj_sel;
  logic [3:0]  adj_val;

  typedef struct {
    string      tag;
    int         lo;
    int         hi;
    logic [9:0] o;
  } ev_t;

  ev_t sb[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;
  int  t0      = 0;

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(DB), .DB_W(4)) dut (
    .clk(clk), .rst(rst),
    .btn_pause(btn_pause), .btn_reset(btn_reset), .btn_inc(btn_inc),
    .sw_adj(sw_adj), .sw_sel(sw_sel), .cnt_digits(cnt_digits),
    .clr(clr), .paused(paused), .adj(adj), .adj_sel(adj_sel), .adj_val(adj_val)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [9:0] ob(input logic c, input logic p, input logic a,
                                    input logic [2:0] s, input logic [3:0] v);
    return {c, p, a, s, v};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_ev(input string tag, input int dlo, input int dhi, input logic [9:0] o);
    ev_t e;
    e.tag = tag;
    e.lo  = t0 + dlo;
    e.hi  = t0 + dhi;
    e.o   = o;
    sb.push_back(e);
  endtask

  // Every change of the output vector outside reset must match the next scoreboard entry.
  task automatic monitor();
    logic [9:0] cur, last;
    ev_t        e;
    int         exp_c;
    last = '0;
    forever begin
      @(negedge clk);
      cur = ob(clr, paused, adj, adj_sel, adj_val);
      if (rst) begin
        last = cur;
      end else if (cur != last) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_change", 32'(cur), 32'(last));
        end else begin
          e = sb.pop_front();
          check_eq(e.tag, 32'(cur), 32'(e.o));
          exp_c = (cyc < e.lo) ? e.lo : ((cyc > e.hi) ? e.hi : cyc);
          check_eq({e.tag, "_cyc"}, 32'(cyc), 32'(exp_c));
        end
        last = cur;
      end
    end
  endtask

  // b = {inc, reset, pause}
  task automatic btn_down(input logic [2:0] b);
    @(negedge clk);
    btn_pause = b[0];
    btn_reset = b[1];
    btn_inc   = b[2];
    t0 = cyc + 1;
  endtask

  task automatic btn_up(input int hold);
    repeat (hold) @(negedge clk);
    btn_pause = 1'b0;
    btn_reset = 1'b0;
    btn_inc   = 1'b0;
    repeat (16) @(negedge clk);
  endtask

  task automatic set_sw(input logic a, input logic [1:0] s);
    @(negedge clk);
    sw_adj = a;
    sw_sel = s;
    t0 = cyc + 1;
  endtask

  task automatic pause_expect(input string tag, input logic p_after);
    btn_down(3'b001);
    expect_ev(tag, LAT, LAT, ob(1'b0, p_after, 1'b0, 3'd0, 4'd0));
    btn_up(6);
  endtask

  task automatic clr_expect(input string tag, input logic [2:0] b, input logic a);
    btn_down(b);
    expect_ev(tag, LAT, LAT, ob(1'b1, 1'b1, a, 3'd0, 4'd0));
    expect_ev({tag, "_end"}, LAT + 1, LAT + 1, ob(1'b0, 1'b1, a, 3'd0, 4'd0));
    btn_up(6);
  endtask

  task automatic inc_expect(input string tag, input logic [2:0] s, input logic [3:0] v);
    btn_down(3'b100);
    expect_ev(tag, LAT, LAT, ob(1'b0, 1'b1, 1'b1, s, v));
    expect_ev({tag, "_end"}, LAT + 1, LAT + 1, ob(1'b0, 1'b1, 1'b1, 3'd0, 4'd0));
    btn_up(6);
  endtask

  initial begin
    rst        = 1'b1;
    btn_pause  = 1'b0;
    btn_reset  = 1'b0;
    btn_inc    = 1'b0;
    sw_adj     = 1'b0;
    sw_sel     = 2'd0;
    cnt_digits = 16'h0000;
    fork
      monitor();
    join_none

    repeat (2) @(negedge clk);
    check_eq("rst_paused", 32'(paused), 32'd1);
    check_eq("rst_adj", 32'(adj), 32'd0);
    check_eq("rst_clr", 32'(clr), 32'd0);
    check_eq("rst_adj_sel", 32'(adj_sel), 32'd0);
    check_eq("rst_adj_val", 32'(adj_val), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    btn_down(3'b001);
    btn_up(2);
    btn_down(3'b001);
    expect_ev("run_first", LAT, LAT, ob(1'b0, 1'b0, 1'b0, 3'd0, 4'd0));
    btn_up(10);

    clr_expect("clr_in_run", 3'b010, 1'b0);
    pause_expect("run_again", 1'b0);
    clr_expect("clr_beats_pause", 3'b011, 1'b0);
    pause_expect("run_from_pause", 1'b0);

    cnt_digits = 16'h0958;
    set_sw(1'b1, 2'd2);
    expect_ev("adj_enter", DB + 1, DB + 3, ob(1'b0, 1'b1, 1'b1, 3'd0, 4'd0));
    repeat (14) @(negedge clk);
    cnt_digits = 16'h1234;
    inc_expect("inc_secl_wrap", 3'b110, 4'd0);
    inc_expect("inc_secl_1", 3'b110, 4'd1);
    set_sw(1'b1, 2'd3);
    repeat (14) @(negedge clk);
    inc_expect("inc_secr_9", 3'b111, 4'd9);
    inc_expect("inc_secr_wrap", 3'b111, 4'd0);
    set_sw(1'b1, 2'd0);
    repeat (14) @(negedge clk);
    inc_expect("inc_minl_1", 3'b100, 4'd1);

    set_sw(1'b1, 2'd1);
    repeat (14) @(negedge clk);
    btn_down(3'b100);
    expect_ev("inc_sel_held", LAT, LAT, ob(1'b0, 1'b1, 1'b1, 3'b101, 4'd0));
    expect_ev("inc_sel_held_end", LAT + 1, LAT + 1, ob(1'b0, 1'b1, 1'b1, 3'd0, 4'd0));
    repeat (5) @(negedge clk);
    sw_sel = 2'd3;
    btn_up(1);

    clr_expect("clr_in_adj", 3'b010, 1'b1);
    set_sw(1'b1, 2'd2);
    repeat (14) @(negedge clk);
    inc_expect("inc_after_zero", 3'b110, 4'd1);
    clr_expect("clr_beats_inc", 3'b110, 1'b1);
    inc_expect("inc_after_zero2", 3'b110, 4'd1);

    btn_down(3'b001);
    btn_up(6);
    set_sw(1'b0, 2'd2);
    expect_ev("adj_leave", DB + 1, DB + 3, ob(1'b0, 1'b1, 1'b0, 3'd0, 4'd0));
    repeat (14) @(negedge clk);
    btn_down(3'b100);
    btn_up(6);
    pause_expect("run_after_adj", 1'b0);

    btn_down(3'b001);
    repeat (3) @(negedge clk);
    rst       = 1'b1;
    btn_pause = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_mid_paused", 32'(paused), 32'd1);
    check_eq("rst_mid_clr", 32'(clr), 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    pause_expect("run_after_rst", 1'b0);

    repeat (5) @(negedge clk);
    check_eq("sb_drain", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
